// File: rtl/sa_ctrl_if.sv
// sa_ctrl_if
// Purpose: stream handshakes around the systolic-array sequencer.
//   Input side : s_valid/s_last from the x/k source, s_ready back to it.
//   Output side: m_axis_valid/m_axis_last to the result sink, m_axis_ready back.
// Modports:
//   master - stimulus/sink side (drives s_valid, s_last, m_axis_ready)
//   slave  - sequencer side     (drives s_ready, m_axis_valid, m_axis_last)
interface sa_ctrl_if;
  logic s_valid;
  logic s_last;
  logic s_ready;
  logic m_axis_valid;
  logic m_axis_ready;
  logic m_axis_last;

  modport master (
    output s_valid, s_last, m_axis_ready,
    input  s_ready, m_axis_valid, m_axis_last
  );

  modport slave (
    input  s_valid, s_last, m_axis_ready,
    output s_ready, m_axis_valid, m_axis_last
  );
endinterface

// File: rtl/sa_ctrl.sv
// sa_ctrl
// Purpose: control sequencer for an R x C systolic array of pe/mac cells.
//   Tracks accepted x/k beats through a P-stage valid/first/last pipeline,
//   drives the array-wide MAC enable and the per-diagonal (d = row+col)
//   m_valid/m_first/r_copy strobes, then drains each finished tile out of
//   the ro shift chain as an R-beat stream. Carries no data.
// Ports:
//   clk, rstn     clock; synchronous active-low reset
//   bus_if        sa_ctrl_if.slave: s_valid/s_last/s_ready in, m_axis_* out
//   en_mac_o      global MAC / skew-register enable
//   m_valid_o     per-diagonal beat valid        [D-1:0]
//   m_first_o     per-diagonal first-beat-of-tile [D-1:0]
//   r_copy_o      per-diagonal accumulator->ro copy [D-1:0]
//   en_shift_o    ro chain shift
//   busy_o        pipeline non-empty or a tile pending/draining
module sa_ctrl #(
  parameter int R  = 4,
  parameter int C  = 4,
  parameter int LM = 1,
  parameter int LA = 1
) (
  input  logic             clk,
  input  logic             rstn,
  sa_ctrl_if.slave         bus_if,
  output logic             en_mac_o,
  output logic [R+C-2:0]   m_valid_o,
  output logic [R+C-2:0]   m_first_o,
  output logic [R+C-2:0]   r_copy_o,
  output logic             en_shift_o,
  output logic             busy_o
);

  localparam int D  = R + C - 1;
  localparam int P  = D + LM + LA;
  localparam int CW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COPY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [P-1:0]    v_q, v_d;
  logic [P-1:0]    l_q, l_d;
  // The first flag is only consumed at the diagonal taps, so it stops at D.
  logic [D-1:0]    f_q, f_d;
  logic            first_q, first_d;
  logic            pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            s_ready_s;
  logic            acc_s;
  logic            en_mac_s;
  logic [D-1:0]    r_copy_s;
  logic            drain_s;
  logic            hs_s;
  logic            last_beat_s;
  logic            drain_done_s;

  // A tile end is held off until the previous tile has left the ro chain;
  // this is the only guard, the array itself never stalls.
  assign s_ready_s    = ~(bus_if.s_last & pend_q);
  assign acc_s        = bus_if.s_valid & s_ready_s;
  assign en_mac_s     = acc_s | (|v_q);
  // A last beat reaching stage d+LM+LA means diagonal d has its final sum.
  assign r_copy_s     = {D{en_mac_s}} & v_q[P-1:LM+LA] & l_q[P-1:LM+LA];
  assign drain_s      = (state_q == DRAIN);
  assign hs_s         = drain_s & bus_if.m_axis_ready;
  assign last_beat_s  = drain_s & (cnt_q == CW'(R - 1));
  assign drain_done_s = hs_s & last_beat_s;

  // Pipeline next state: shift by one stage on every enabled cycle.
  always_comb begin
    v_d = v_q;
    l_d = l_q;
    f_d = f_q;
    if (en_mac_s) begin
      v_d[0] = acc_s;
      l_d[0] = acc_s & bus_if.s_last;
      f_d[0] = acc_s & first_q;
      for (int i = 1; i < P; i++) begin
        v_d[i] = v_q[i-1];
        l_d[i] = l_q[i-1];
      end
      for (int i = 1; i < D; i++) begin
        f_d[i] = f_q[i-1];
      end
    end else begin
      v_d = v_q;
      l_d = l_q;
      f_d = f_q;
    end
  end

  // Tile bookkeeping: first-beat flag and pending-drain flag.
  always_comb begin
    first_d = first_q;
    pend_d  = pend_q;
    if (acc_s) begin
      first_d = bus_if.s_last;
    end else begin
      first_d = first_q;
    end
    if (acc_s & bus_if.s_last) begin
      pend_d = 1'b1;
    end else if (drain_done_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Drain FSM next state and beat counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (r_copy_s[0]) begin
          state_d = (D == 1) ? DRAIN : COPY;
        end else begin
          state_d = IDLE;
        end
      end
      COPY: begin
        if (r_copy_s[D-1]) begin
          state_d = DRAIN;
        end else begin
          state_d = COPY;
        end
      end
      DRAIN: begin
        if (drain_done_s) begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
        end else if (hs_s) begin
          cnt_d   = cnt_q + CW'(1);
        end else begin
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      v_q     <= {P{1'b0}};
      l_q     <= {P{1'b0}};
      f_q     <= {D{1'b0}};
      first_q <= 1'b1;
      pend_q  <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      l_q     <= l_d;
      f_q     <= f_d;
      first_q <= first_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign en_mac_o            = en_mac_s;
  assign m_valid_o           = v_q[D-1:0];
  assign m_first_o           = v_q[D-1:0] & f_q;
  assign r_copy_o            = r_copy_s;
  // Beat 0 is the copied bottom row itself, so shifting only follows a handshake.
  assign en_shift_o          = hs_s;
  assign busy_o              = (|v_q) | pend_q;
  assign bus_if.s_ready      = s_ready_s;
  assign bus_if.m_axis_valid = drain_s;
  assign bus_if.m_axis_last  = last_beat_s;

endmodule

// File: tb/tb_sa_ctrl.sv
// tb_sa_ctrl
// Purpose: self-checking bench for sa_ctrl (R=C=4, LM=LA=1, D=7).
//   Cycle table for a K=3 tile, hand-written sequences for the multi-cycle
//   corners, and a scoreboard of expected output beats (last flag per beat)
//   pushed on tile-end acceptance and popped on each output handshake.
module tb_sa_ctrl;
  localparam int R = 4;
  localparam int C = 4;
  localparam int D = 7;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  sa_ctrl_if bus();
  logic         en_mac;
  logic [D-1:0] m_valid;
  logic [D-1:0] m_first;
  logic [D-1:0] r_copy;
  logic         en_shift;
  logic         busy;

  sa_ctrl #(.R(R), .C(C), .LM(1), .LA(1)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus_if     (bus),
    .en_mac_o   (en_mac),
    .m_valid_o  (m_valid),
    .m_first_o  (m_first),
    .r_copy_o   (r_copy),
    .en_shift_o (en_shift),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  logic sb_q[$];

  typedef struct packed {
    logic       sv;
    logic       sl;
    logic [6:0] mv;
    logic [6:0] mf;
    logic [6:0] rc;
    logic       em;
    logic       es;
    logic       axv;
    logic       axl;
    logic       bsy;
    logic       srdy;
  } vec_t;

  vec_t t1[17];
  vec_t exp_rst;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t sample();
    return {bus.s_valid, bus.s_last, m_valid, m_first, r_copy, en_mac, en_shift,
            bus.m_axis_valid, bus.m_axis_last, busy, bus.s_ready};
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive(input logic sv, input logic sl);
    bus.s_valid = sv;
    bus.s_last  = sl;
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    drive(1'b0, 1'b0);
    while (k < max) begin
      settle();
      if (busy === 1'b0) break;
      nxt();
      k++;
    end
    chk("idle_timeout", (k >= max), 1'b0);
    nxt();
  endtask

  task automatic wait_axv(input int max);
    int k = 0;
    while (k < max) begin
      settle();
      if (bus.m_axis_valid === 1'b1) break;
      nxt();
      k++;
    end
    chk("axv_timeout", (k >= max), 1'b0);
  endtask

  task automatic run_t1(input string tag);
    for (int i = 0; i < 17; i++) begin
      drive(t1[i].sv, t1[i].sl);
      settle();
      chk($sformatf("%s_c%0d", tag, i), sample(), t1[i]);
      nxt();
    end
    drive(1'b0, 1'b0);
  endtask

  function automatic logic [6:0] k1_taps(input int c);
    logic [6:0] m = 7'b0000000;
    for (int d = 0; d < D; d++) begin
      if (c == 1 + d || c == 15 + d || c == 29 + d) m[d] = 1'b1;
    end
    return m;
  endfunction

  // Scoreboard: expected beats on tile-end acceptance, compared on handshake.
  always @(negedge clk) begin
    if (!rstn) begin
      sb_q.delete();
    end else begin
      if (bus.s_valid && bus.s_ready && bus.s_last) begin
        for (int i = 0; i < R; i++) sb_q.push_back(i == R - 1);
      end
      if (bus.m_axis_valid && bus.m_axis_ready) begin
        if (sb_q.size() == 0) chk("sb_unexpected_beat", 1'b1, 1'b0);
        else                  chk("sb_last", bus.m_axis_last, sb_q.pop_front());
        chk("sb_shift_on_hs", en_shift, 1'b1);
        chk("sb_copy_vs_shift", r_copy, 7'b0000000);
      end else begin
        chk("sb_no_shift", en_shift, 1'b0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       pat[7];
    logic [10:0] mv0;
    logic [10:0] mv3;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    mv0 = 11'b00001000110;
    mv3 = 11'b01000110000;

    //           sv    sl    m_valid     m_first     r_copy      em    es    axv   axl   busy  srdy
    t1[0]  = {1'b1, 1'b0, 7'b0000000, 7'b0000000, 7'b0000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    t1[1]  = {1'b1, 1'b0, 7'b0000001, 7'b0000001, 7'b0000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t1[2]  = {1'b1, 1'b1, 7'b0000011, 7'b0000010, 7'b0000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t1[3]  = {1'b0, 1'b0, 7'b0000111, 7'b0000100, 7'b0000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t1[4]  = {1'b0, 1'b0, 7'b0001110, 7'b0001000, 7'b0000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t1[5]  = {1'b0, 1'b0, 7'b0011100, 7'b0010000, 7'b0000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t1[6]  = {1'b0, 1'b0, 7'b0111000, 7'b0100000, 7'b0000010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t1[7]  = {1'b0, 1'b0, 7'b1110000, 7'b1000000, 7'b0000100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t1[8]  = {1'b0, 1'b0, 7'b1100000, 7'b0000000, 7'b0001000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t1[9]  = {1'b0, 1'b0, 7'b1000000, 7'b0000000, 7'b0010000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t1[10] = {1'b0, 1'b0, 7'b0000000, 7'b0000000, 7'b0100000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t1[11] = {1'b0, 1'b0, 7'b0000000, 7'b0000000, 7'b1000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t1[12] = {1'b0, 1'b0, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    t1[13] = {1'b0, 1'b0, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    t1[14] = {1'b0, 1'b0, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    t1[15] = {1'b0, 1'b0, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    t1[16] = {1'b0, 1'b0, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_rst = {1'b0, 1'b0, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    drive(1'b0, 1'b0);
    bus.m_axis_ready = 1'b1;
    rstn = 1'b0;
    nxt();
    nxt();
    rstn = 1'b1;
    settle();
    chk("reset_state", sample(), exp_rst);
    nxt();

    // Test 1: single K=3 tile, cycle-exact table
    run_t1("t1");
    wait_idle(20);

    // Test 2: second tile's last beat presented during the first tile's drain
    for (int c = 0; c <= 16; c++) begin
      if (c < 2)       drive(1'b1, 1'b0);
      else if (c == 2) drive(1'b1, 1'b1);
      else if (c < 12) drive(1'b1, 1'b0);
      else             drive(1'b1, 1'b1);
      settle();
      chk($sformatf("t2_ready_c%0d", c), bus.s_ready, (c >= 12 && c <= 15) ? 1'b0 : 1'b1);
      if (c >= 1) chk($sformatf("t2_first0_c%0d", c), m_first[0], (c == 1 || c == 4));
      nxt();
    end
    wait_idle(60);

    // Test 3: downstream backpressure pattern during drain
    drive(1'b1, 1'b0);
    nxt();
    drive(1'b1, 1'b1);
    nxt();
    drive(1'b0, 1'b0);
    wait_axv(40);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        nxt();
        bus.m_axis_ready = pat[i];
        settle();
      end
      chk($sformatf("t3_valid_%0d", i), bus.m_axis_valid, 1'b1);
      chk($sformatf("t3_shift_%0d", i), en_shift, pat[i]);
      chk($sformatf("t3_last_%0d", i), bus.m_axis_last, (i == 6));
    end
    nxt();
    bus.m_axis_ready = 1'b1;
    settle();
    chk("t3_valid_after", bus.m_axis_valid, 1'b0);
    wait_idle(20);

    // Test 4: continuous K=1 tiles, serialized by the pending drain
    for (int c = 0; c < 42; c++) begin
      drive(1'b1, 1'b1);
      settle();
      chk($sformatf("t4_ready_c%0d", c), bus.s_ready, ((c % 14) == 0));
      chk($sformatf("t4_valid_c%0d", c), m_valid, k1_taps(c));
      chk($sformatf("t4_first_c%0d", c), m_first, k1_taps(c));
      nxt();
    end
    wait_idle(40);

    // Test 5: three-cycle s_valid gap mid-tile
    for (int c = 0; c <= 10; c++) begin
      drive((c < 2) || (c == 5), (c == 5));
      settle();
      chk($sformatf("t5_mv0_c%0d", c), m_valid[0], mv0[c]);
      chk($sformatf("t5_mv3_c%0d", c), m_valid[3], mv3[c]);
      chk($sformatf("t5_en_c%0d", c), en_mac, 1'b1);
      nxt();
    end
    wait_idle(30);
    settle();
    chk("t5_en_idle", en_mac, 1'b0);
    nxt();

    // Test 6: reset during DRAIN after two beats, then a clean tile
    drive(1'b1, 1'b0);
    nxt();
    nxt();
    drive(1'b1, 1'b1);
    nxt();
    drive(1'b0, 1'b0);
    wait_axv(30);
    nxt();
    nxt();
    rstn = 1'b0;
    settle();
    nxt();
    rstn = 1'b1;
    settle();
    chk("t6_after_reset", sample(), exp_rst);
    nxt();
    run_t1("t6");
    wait_idle(20);

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
